// File: rtl/FSMpackage.sv
// Shared types and constants for the RLE channel arbiter slice.
package FSMpackage;

  localparam int NUM_CH_C    = 4;
  localparam int MAX_BURST_C = 255;
  localparam int SYM_W_C     = 7;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rle_channel_arbiter_if.sv
// Channel-side and encoder-side handshake bundle; master is the arbiter, slave is its environment.
interface rle_channel_arbiter_if;
  import FSMpackage::*;

  logic [NUM_CH_C-1:0]              ch_valid;
  logic [NUM_CH_C-1:0][SYM_W_C-1:0] ch_data;
  logic [NUM_CH_C-1:0]              ch_last;
  logic [NUM_CH_C-1:0]              ch_ready;
  logic                             enc_ready;
  logic [SYM_W_C-1:0]               enc_data;
  logic                             enc_valid;
  logic                             enc_flush;
  logic                             enc_done;

  modport master (
    input  ch_valid, ch_data, ch_last, enc_ready, enc_done,
    output ch_ready, enc_data, enc_valid, enc_flush
  );

  modport slave (
    output ch_valid, ch_data, ch_last, enc_ready, enc_done,
    input  ch_ready, enc_data, enc_valid, enc_flush
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of valid at or after ptr, wrapping.
module rr_priority_picker
  import FSMpackage::*;
(
  input  logic [NUM_CH_C-1:0] valid,
  input  logic [1:0]          ptr,
  output logic                found,
  output logic [1:0]          idx
);

  logic [NUM_CH_C-1:0] rot;

  // rot[k] is the request k positions after the pointer
  generate
    for (genvar gi = 0; gi < NUM_CH_C; gi++) begin : g_rot
      logic [1:0] sel;
      assign sel     = ptr + 2'(gi);
      assign rot[gi] = valid[sel];
    end
  endgenerate

  always_comb begin
    found = |rot;
    idx   = ptr;
    for (int i = NUM_CH_C - 1; i >= 0; i--) begin
      if (rot[i]) idx = ptr + 2'(i);
    end
  end

endmodule

// File: rtl/rle_channel_arbiter.sv
// Grants one of four symbol channels to a shared RLE encoder per frame,
// closing each frame with a flush and waiting for the encoder's done.
module rle_channel_arbiter
  import FSMpackage::*;
#(
  parameter int NUM_CH    = NUM_CH_C,
  parameter int MAX_BURST = MAX_BURST_C
) (
  input  logic                  clock,
  input  logic                  reset_n,
  rle_channel_arbiter_if.master bus,
  output logic [1:0]            grant_id,
  output logic                  busy
);

  localparam int GW = $clog2(NUM_CH);

  arb_state_t          state_reg, state_next;
  logic [GW-1:0]       grant_reg, grant_next;
  logic [GW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [7:0]          burst_cnt_reg, burst_cnt_next;

  logic                pick_found;
  logic [1:0]          pick_idx;
  logic                xfer;
  logic                at_limit;
  logic [NUM_CH_C-1:0] ch_ready_c;
  logic [SYM_W_C-1:0]  enc_data_c;
  logic                enc_valid_c;
  logic                enc_flush_c;

  rr_priority_picker u_picker (
    .valid (bus.ch_valid),
    .ptr   (rr_ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign xfer     = (state_reg == STREAM) && bus.ch_valid[grant_reg] && bus.enc_ready;
  assign at_limit = (9'(burst_cnt_reg) + 9'd1) == 9'(MAX_BURST);

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    ch_ready_c     = '0;
    enc_data_c     = '0;
    enc_valid_c    = 1'b0;
    enc_flush_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next     = pick_idx;
          burst_cnt_next = '0;
          state_next     = STREAM;
        end
      end
      STREAM: begin
        // zero-latency pass-through of the granted channel
        enc_valid_c           = bus.ch_valid[grant_reg];
        enc_data_c            = bus.ch_data[grant_reg];
        ch_ready_c[grant_reg] = bus.enc_ready;
        if (xfer) begin
          burst_cnt_next = burst_cnt_reg + 8'd1;
          if (bus.ch_last[grant_reg] || at_limit) state_next = FLUSH;
        end
      end
      FLUSH: begin
        enc_flush_c = 1'b1;
        state_next  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.enc_done) begin
          rr_ptr_next = grant_reg + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  assign bus.ch_ready  = ch_ready_c;
  assign bus.enc_data  = enc_data_c;
  assign bus.enc_valid = enc_valid_c;
  assign bus.enc_flush = enc_flush_c;
  assign grant_id      = grant_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_rle_channel_arbiter.sv
// Scoreboard bench: stimulus queues expected transfers/flushes, a negedge monitor pops and checks.
module tb_rle_channel_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] grant_id;
  logic       busy;

  rle_channel_arbiter_if bus ();

  rle_channel_arbiter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_flush;
    logic [1:0] ch;
    logic [6:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] chq[4][$];
  bit         bp_pat[$];
  bit         bp_mode = 0;
  bit   [3:0] acc = '0;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_xfer_cyc = 0;
  bit         done_pending = 0;
  int         done_wait = 0;
  int         done_delay = 0;
  logic [1:0] pending_grant = '0;
  int         wait_viol = 0;
  int         late_cycles = 0;
  int         xcnt[4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_x(input logic [1:0] ch, input logic [6:0] d);
    exp_q.push_back('{1'b0, ch, d});
  endtask

  task automatic push_f(input logic [1:0] ch);
    exp_q.push_back('{1'b1, ch, 7'h00});
  endtask

  task automatic load(input int ch, input logic [6:0] d, input bit last);
    chq[ch].push_back({last, d});
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy || done_pending) && n < max) begin
      @(posedge clock);
      #3;
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s timeout: %0d events left, busy=%0b", name, exp_q.size(), busy);
    end
  endtask

  // channel sources and encoder ready
  always @(posedge clock) begin
    logic [3:0]      v;
    logic [3:0]      l;
    logic [3:0][6:0] d;
    cyc++;
    #1;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < 4; k++) begin
      if (acc[k] && chq[k].size() > 0) void'(chq[k].pop_front());
      if (chq[k].size() > 0) begin
        v[k] = 1'b1;
        l[k] = chq[k][0][7];
        d[k] = chq[k][0][6:0];
      end
    end
    bus.ch_valid = v;
    bus.ch_last  = l;
    bus.ch_data  = d;
    #1;
    if (bp_pat.size() > 0 && bus.enc_valid && grant_id == 2'd2) bus.enc_ready = bp_pat.pop_front();
    else bus.enc_ready = 1'b1;
  end

  // monitor plus encoder done responder
  always @(negedge clock) begin
    ev_t e;
    if (bus.enc_done) bus.enc_done = 1'b0;
    if (reset_n) begin
      if (done_pending) begin
        late_cycles++;
        if (bus.ch_ready != 4'b0 || bus.enc_valid || !busy || grant_id != pending_grant) wait_viol++;
      end
      if (bus.enc_valid && bus.enc_ready) begin
        checks++;
        xcnt[grant_id]++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer: got ch%0d data %02h, expected nothing", grant_id, bus.enc_data);
        end else begin
          e = exp_q.pop_front();
          if (e.is_flush || e.ch != grant_id || e.data != bus.enc_data) begin
            errors++;
            $display("FAIL xfer: got ch%0d data %02h, expected %s ch%0d data %02h",
                     grant_id, bus.enc_data, e.is_flush ? "flush" : "xfer", e.ch, e.data);
          end
        end
        last_xfer_cyc = cyc;
      end
      if (bp_mode && bus.enc_valid && grant_id == 2'd2) begin
        checks++;
        if (bus.ch_ready != (4'(bus.enc_ready) << 2)) begin
          errors++;
          $display("FAIL bp_ready: got ch_ready %b expected %b", bus.ch_ready, 4'(bus.enc_ready) << 2);
        end
      end
      if (done_pending) begin
        if (done_wait == 0) begin
          bus.enc_done = 1'b1;
          done_pending = 0;
        end else begin
          done_wait--;
        end
      end
      if (bus.enc_flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL flush: got flush on ch%0d, expected nothing", grant_id);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_flush || e.ch != grant_id || cyc - last_xfer_cyc != 1) begin
            errors++;
            $display("FAIL flush: got flush ch%0d gap %0d, expected %s ch%0d gap 1",
                     grant_id, cyc - last_xfer_cyc, e.is_flush ? "flush" : "xfer", e.ch);
          end
        end
        done_pending  = 1;
        done_wait     = done_delay;
        pending_grant = grant_id;
      end
    end
    acc = bus.ch_valid & bus.ch_ready;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset grant", 32'(grant_id), 0);
    chk("reset enc_valid", 32'(bus.enc_valid), 0);
    chk("reset ch_ready", 32'(bus.ch_ready), 0);
    chk("reset enc_flush", 32'(bus.enc_flush), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // round robin from pointer 0: 0,1,2,3,0
    load(0, 7'h11, 1); load(0, 7'h15, 1);
    load(1, 7'h12, 1); load(2, 7'h13, 1); load(3, 7'h14, 1);
    push_x(0, 7'h11); push_f(0); push_x(1, 7'h12); push_f(1);
    push_x(2, 7'h13); push_f(2); push_x(3, 7'h14); push_f(3);
    push_x(0, 7'h15); push_f(0);
    drain("round_robin", 200);

    // single channel frame on ch1
    load(1, 7'h05, 0); load(1, 7'h05, 0); load(1, 7'h07, 1);
    push_x(1, 7'h05); push_x(1, 7'h05); push_x(1, 7'h07); push_f(1);
    drain("single", 100);

    // backpressure on ch2
    bp_mode = 1;
    bp_pat.push_back(1); bp_pat.push_back(0); bp_pat.push_back(1);
    load(2, 7'h21, 0); load(2, 7'h22, 1);
    push_x(2, 7'h21); push_x(2, 7'h22); push_f(2);
    drain("backpressure", 100);
    bp_mode = 0;
    chk("bp pattern consumed", 32'(bp_pat.size()), 0);

    // truncation: 255 then others then the remaining 45
    for (int i = 0; i < 300; i++) load(3, 7'(i), i == 299);
    for (int i = 0; i < 255; i++) push_x(3, 7'(i));
    push_f(3);
    push_x(0, 7'h30); push_f(0); push_x(1, 7'h31); push_f(1);
    for (int i = 255; i < 300; i++) push_x(3, 7'(i));
    push_f(3);
    repeat (5) @(posedge clock);
    load(0, 7'h30, 1); load(1, 7'h31, 1);
    drain("truncation", 2000);
    chk("trunc ch3 transfers", 32'(xcnt[3]), 301);

    // late done with ch1 waiting
    done_delay = 20; late_cycles = 0; wait_viol = 0;
    load(0, 7'h40, 1); load(1, 7'h41, 1);
    push_x(0, 7'h40); push_f(0); push_x(1, 7'h41); push_f(1);
    drain("late_done", 300);
    done_delay = 0;
    chk("late done violations", 32'(wait_viol), 0);
    chk("late done wait cycles", 32'(late_cycles), 42);

    // reset mid-frame on ch0
    for (int i = 0; i < 20; i++) load(0, 7'h50 + 7'(i), 0);
    for (int i = 0; i < 10; i++) push_x(0, 7'h50 + 7'(i));
    base = xcnt[0];
    n = 0;
    while (xcnt[0] < base + 10 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("reset wait 10 xfers", 32'(xcnt[0] - base), 10);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async enc_valid", 32'(bus.enc_valid), 0);
    chk("async ch_ready", 32'(bus.ch_ready), 0);
    chk("async enc_flush", 32'(bus.enc_flush), 0);
    chk("async busy", 32'(busy), 0);
    chk("async grant", 32'(grant_id), 0);
    chq[0].delete();
    chk("reset xfers seen", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    // pointer back at 0: ch0 wins over ch2
    load(0, 7'h60, 1); load(2, 7'h62, 1);
    push_x(0, 7'h60); push_f(0); push_x(2, 7'h62); push_f(2);
    drain("after_reset", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
